// File: rtl/sram_write_sequencer_pkg.sv
// Shared types for the SRAM write sequencer: controller state and index sizing.
package sram_write_sequencer_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } sram_seq_state_t;

    // Width needed to index n items; never less than one bit.
    function automatic int unsigned index_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_write_sequencer_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or above the
// rotating priority pointer; the pointer moves past the winner on update_lru.
module rr_arbiter
    import sram_write_sequencer_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic                      update_lru,
    output logic [NUM_REQUESTERS-1:0] grant_oh
);

    localparam int unsigned PTR_WIDTH = index_width(NUM_REQUESTERS);

    logic [PTR_WIDTH-1:0]        pointer;
    logic [PTR_WIDTH-1:0]        next_pointer;
    logic [NUM_REQUESTERS-1:0]   rotated;
    logic [NUM_REQUESTERS-1:0]   grant_rot;
    logic                        found;

    // Rotate requests so the pointer sits at bit 0, pick the lowest set bit,
    // then rotate the grant back into requester order.
    always_comb begin
        rotated      = NUM_REQUESTERS'({request, request} >> pointer);
        grant_rot    = '0;
        next_pointer = pointer;
        found        = 1'b0;
        for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
            if (!found && rotated[k]) begin
                found        = 1'b1;
                grant_rot[k] = 1'b1;
                next_pointer = PTR_WIDTH'((32'(pointer) + k + 1) % NUM_REQUESTERS);
            end
        end
        grant_oh = NUM_REQUESTERS'(({grant_rot, grant_rot} << pointer) >> NUM_REQUESTERS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pointer <= '0;
        end else if (update_lru) begin
            pointer <= next_pointer;
        end
    end

endmodule

// File: rtl/sram_write_sequencer.sv
// Owns the single write port of a sram_2r1w: clears every entry after reset or
// flush, otherwise grants the port round-robin to valid/ready requesters.
module sram_write_sequencer
    import sram_write_sequencer_pkg::*;
#(
    parameter int unsigned           NUM_REQUESTERS = 2,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           SIZE           = 1024,
    parameter int unsigned           ADDR_WIDTH     = $clog2(SIZE),
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
    parameter bit                    CLEAR_ON_RESET = 1'b1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      flush_en,
    input  logic [NUM_REQUESTERS-1:0]                 req_valid,
    input  logic [NUM_REQUESTERS-1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQUESTERS-1:0]                 req_ready,
    output logic                                      init_done,
    output logic                                      sram_write_en,
    output logic [ADDR_WIDTH-1:0]                     sram_write_addr,
    output logic [DATA_WIDTH-1:0]                     sram_write_data
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(SIZE - 1);
    localparam sram_seq_state_t       RESET_STATE = CLEAR_ON_RESET ? CLEAR : ARB;
    localparam logic                  RESET_DONE  = CLEAR_ON_RESET ? 1'b0 : 1'b1;

    sram_seq_state_t           state, state_next;
    logic [ADDR_WIDTH-1:0]     clear_count, clear_count_next;
    logic                      init_done_next;
    logic                      write_en_next;
    logic [ADDR_WIDTH-1:0]     write_addr_next;
    logic [DATA_WIDTH-1:0]     write_data_next;

    logic                      arb_live;
    logic                      flush_take;
    logic                      clear_step;
    logic                      transfer;
    logic [NUM_REQUESTERS-1:0] arb_request;
    logic [NUM_REQUESTERS-1:0] grant;
    logic [ADDR_WIDTH-1:0]     sel_addr;
    logic [DATA_WIDTH-1:0]     sel_data;

    // Arbitration waits for init_done so the first grant lands the cycle after
    // the final clear write; an accepted flush issues clear write 0 at once,
    // putting the clear writes at T+1..T+SIZE.
    assign arb_live    = (state == ARB) && init_done;
    assign flush_take  = arb_live && flush_en;
    assign clear_step  = (state == CLEAR) || flush_take;
    assign arb_request = (arb_live && !flush_en && !reset) ? req_valid : '0;
    assign transfer    = |grant;
    assign req_ready   = grant;

    rr_arbiter #(
        .NUM_REQUESTERS(NUM_REQUESTERS)
    ) u_arbiter (
        .clk       (clk),
        .reset     (reset),
        .request   (arb_request),
        .update_lru(transfer),
        .grant_oh  (grant)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | req_addr[i];
                sel_data = sel_data | req_data[i];
            end
        end
    end

    always_comb begin
        state_next       = state;
        clear_count_next = clear_count;
        write_en_next    = 1'b0;
        write_addr_next  = sram_write_addr;
        write_data_next  = sram_write_data;
        init_done_next   = (state == ARB) && !flush_take;
        if (clear_step) begin
            write_en_next   = 1'b1;
            write_addr_next = clear_count;
            write_data_next = CLEAR_VALUE;
            if (clear_count == LAST_ADDR) begin
                state_next       = ARB;
                clear_count_next = '0;
            end else begin
                state_next       = CLEAR;
                clear_count_next = clear_count + 1'b1;
            end
        end else if (transfer) begin
            write_en_next   = 1'b1;
            write_addr_next = sel_addr;
            write_data_next = sel_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= RESET_STATE;
            clear_count     <= '0;
            init_done       <= RESET_DONE;
            sram_write_en   <= 1'b0;
            sram_write_addr <= '0;
            sram_write_data <= '0;
        end else begin
            state           <= state_next;
            clear_count     <= clear_count_next;
            init_done       <= init_done_next;
            sram_write_en   <= write_en_next;
            sram_write_addr <= write_addr_next;
            sram_write_data <= write_data_next;
        end
    end

endmodule

// File: tb/tb_sram_write_sequencer.sv
// Self-checking bench: clear/arbitration behaviour against a queue-free
// priority-scan reference model and a backing SRAM with NEW_DATA reads.
module tb_sram_write_sequencer;

    localparam int NR = 2;
    localparam int DW = 32;
    localparam int SZ = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                  flush_en;
    logic [NR-1:0]         req_valid, req_ready;
    logic [NR-1:0][AW-1:0] req_addr;
    logic [NR-1:0][DW-1:0] req_data;
    logic                  init_done, we;
    logic [AW-1:0]         wa;
    logic [DW-1:0]         wd;

    logic                  nc_flush_en;
    logic [NR-1:0]         nc_req_valid, nc_req_ready;
    logic [NR-1:0][AW-1:0] nc_req_addr;
    logic [NR-1:0][DW-1:0] nc_req_data;
    logic                  nc_init_done, nc_we;
    logic [AW-1:0]         nc_wa;
    logic [DW-1:0]         nc_wd;

    sram_write_sequencer #(
        .NUM_REQUESTERS(NR), .DATA_WIDTH(DW), .SIZE(SZ), .ADDR_WIDTH(AW),
        .CLEAR_VALUE('0), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .flush_en(flush_en),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .init_done(init_done),
        .sram_write_en(we), .sram_write_addr(wa), .sram_write_data(wd)
    );

    sram_write_sequencer #(
        .NUM_REQUESTERS(NR), .DATA_WIDTH(DW), .SIZE(SZ), .ADDR_WIDTH(AW),
        .CLEAR_VALUE('0), .CLEAR_ON_RESET(1'b0)
    ) dut_nc (
        .clk(clk), .reset(reset), .flush_en(nc_flush_en),
        .req_valid(nc_req_valid), .req_addr(nc_req_addr), .req_data(nc_req_data),
        .req_ready(nc_req_ready), .init_done(nc_init_done),
        .sram_write_en(nc_we), .sram_write_addr(nc_wa), .sram_write_data(nc_wd)
    );

    // Backing SRAM, NEW_DATA read-during-write
    logic [DW-1:0] mem [SZ];
    logic          fill_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < SZ; i++) mem[i] <= 32'hA5A5_A5A5;
        end else if (we) begin
            mem[wa] <= wd;
        end
        rd_data <= (we && wa == rd_addr) ? wd : mem[rd_addr];
    end

    // Reference model state
    int unsigned   ptr;
    logic [DW-1:0] exp_mem [SZ];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic test_reset();
        reset = 1'b1; flush_en = 1'b0; fill_en = 1'b1; rd_addr = '0;
        req_valid = '0; req_addr = '0; req_data = '0;
        nc_flush_en = 1'b0; nc_req_valid = 2'b01; nc_req_addr = '0; nc_req_data = '0;
        repeat (2) @(posedge clk);
        #1; fill_en = 1'b0;
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", we); end
        n_checks++; if (wa !== '0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", wa); end
        n_checks++; if (wd !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", wd); end
        n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
        n_checks++; if (nc_init_done !== 1'b1) begin n_fail++; $display("FAIL reset_nc_init_done: got %b expected 1", nc_init_done); end
        n_checks++; if (nc_req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_nc_ready: got %b expected 00", nc_req_ready); end
        nc_req_valid = '0;
        ptr = 0;
    endtask

    task automatic test_clear_sequence();
        req_valid = 2'b11; req_addr[0] = 4'd3; req_addr[1] = 4'd4;
        req_data[0] = 32'h1111_0000; req_data[1] = 32'h2222_0000;
        for (int k = 1; k <= SZ; k++) begin
            @(posedge clk); #1;
            n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL clear_we[%0d]: got %b expected 1", k, we); end
            n_checks++; if (wa !== AW'(k - 1)) begin n_fail++; $display("FAIL clear_addr[%0d]: got %0d expected %0d", k, wa, k - 1); end
            n_checks++; if (wd !== '0) begin n_fail++; $display("FAIL clear_data[%0d]: got %h expected 0", k, wd); end
            n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL clear_init_done[%0d]: got %b expected 0", k, init_done); end
            n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL clear_ready[%0d]: got %b expected 00", k, req_ready); end
        end
        @(posedge clk); #1;
        n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL clear_done_rise: got %b expected 1", init_done); end
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL clear_gap_we: got %b expected 0", we); end
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL clear_first_grant: got %b expected 01", req_ready); end
        req_valid = '0;
        for (int i = 0; i < SZ; i++) exp_mem[i] = '0;
    endtask

    task automatic test_readback(input string tag);
        for (int a = 0; a < SZ; a++) begin
            rd_addr = AW'(a);
            @(posedge clk); #1;
            n_checks++; if (rd_data !== exp_mem[a]) begin n_fail++; $display("FAIL %s_read[%0d]: got %h expected %h", tag, a, rd_data, exp_mem[a]); end
        end
    endtask

    task automatic test_single();
        req_valid = 2'b10; req_addr[1] = 4'd5; req_data[1] = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %b expected 10", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b expected 1", we); end
        n_checks++; if (wa !== 4'd5) begin n_fail++; $display("FAIL single_addr: got %0d expected 5", wa); end
        n_checks++; if (wd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_data: got %h expected deadbeef", wd); end
        exp_mem[5] = 32'hDEAD_BEEF;
        ptr = 0;
        @(posedge clk); #1;
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL single_idle_we: got %b expected 0", we); end
        rd_addr = 4'd5;
        @(posedge clk); #1;
        n_checks++; if (rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_read: got %h expected deadbeef", rd_data); end
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] exp_pat [6];
        int            gi;
        exp_pat = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        for (int c = 0; c < 6; c++) begin
            req_valid = 2'b11;
            req_addr[0] = AW'(2 * c); req_addr[1] = AW'(2 * c + 1);
            req_data[0] = $urandom; req_data[1] = $urandom;
            @(negedge clk);
            n_checks++; if (req_ready !== exp_pat[c]) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected %b", c, req_ready, exp_pat[c]); end
            gi = (c % 2 == 0) ? 0 : 1;
            @(posedge clk); #1;
            n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL b2b_we[%0d]: got %b expected 1", c, we); end
            n_checks++; if (wa !== req_addr[gi]) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %0d expected %0d", c, wa, req_addr[gi]); end
            n_checks++; if (wd !== req_data[gi]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", c, wd, req_data[gi]); end
            exp_mem[req_addr[gi]] = req_data[gi];
            ptr = (gi + 1) % NR;
        end
        req_valid = '0;
    endtask

    task automatic test_random_traffic();
        bit            pend  [NR];
        logic [AW-1:0] paddr [NR];
        logic [DW-1:0] pdata [NR];
        logic [NR-1:0] exp_rdy;
        int            gi;
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 9) < 6) begin
                    pend[i]  = 1'b1;
                    paddr[i] = AW'($urandom_range(0, SZ - 1));
                    pdata[i] = $urandom;
                end
                req_valid[i] = pend[i]; req_addr[i] = paddr[i]; req_data[i] = pdata[i];
            end
            gi = -1;
            for (int k = 0; k < NR; k++) begin
                if (gi < 0 && pend[(ptr + k) % NR]) gi = int'((ptr + k) % NR);
            end
            exp_rdy = '0;
            if (gi >= 0) exp_rdy[gi] = 1'b1;
            @(negedge clk);
            n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", cyc, req_ready, exp_rdy); end
            @(posedge clk); #1;
            n_checks++; if (we !== (gi >= 0)) begin n_fail++; $display("FAIL rand_we[%0d]: got %b expected %b", cyc, we, gi >= 0); end
            if (gi >= 0) begin
                n_checks++; if (wa !== paddr[gi]) begin n_fail++; $display("FAIL rand_addr[%0d]: got %0d expected %0d", cyc, wa, paddr[gi]); end
                n_checks++; if (wd !== pdata[gi]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", cyc, wd, pdata[gi]); end
                exp_mem[paddr[gi]] = pdata[gi];
                pend[gi] = 1'b0;
                ptr = (gi + 1) % NR;
            end
        end
        req_valid = '0;
    endtask

    task automatic test_flush();
        if (ptr == 0) begin
            req_valid = 2'b01; req_addr[0] = 4'd9; req_data[0] = 32'h0000_0909;
            @(posedge clk); #1;
            req_valid = '0;
            n_checks++; if (wa !== 4'd9) begin n_fail++; $display("FAIL flush_prep_addr: got %0d expected 9", wa); end
            ptr = 1;
        end
        req_valid = 2'b11; req_addr[0] = 4'd2; req_addr[1] = 4'd12;
        req_data[0] = 32'hAAAA_0002; req_data[1] = 32'hBBBB_000C;
        flush_en = 1'b1;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL flush_ready: got %b expected 00", req_ready); end
        for (int k = 1; k <= SZ; k++) begin
            @(posedge clk); #1;
            flush_en = 1'b0;
            n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL flush_init_done[%0d]: got %b expected 0", k, init_done); end
            n_checks++; if (we !== 1'b1 || wa !== AW'(k - 1) || wd !== '0) begin n_fail++; $display("FAIL flush_clear[%0d]: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=0", k, we, wa, wd, k - 1); end
        end
        @(posedge clk); #1;
        n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL flush_done_rise: got %b expected 1", init_done); end
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL flush_first_grant: got %b expected 10", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        n_checks++; if (we !== 1'b1 || wa !== 4'd12 || wd !== 32'hBBBB_000C) begin n_fail++; $display("FAIL flush_post_write: got we=%b addr=%0d data=%h expected we=1 addr=12 data=bbbb000c", we, wa, wd); end
        for (int i = 0; i < SZ; i++) exp_mem[i] = '0;
        exp_mem[12] = 32'hBBBB_000C;
        ptr = 0;
    endtask

    task automatic test_reset_mid_clear();
        flush_en = 1'b1;
        @(posedge clk); #1;
        flush_en = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        n_checks++; if (we !== 1'b1 || wa !== 4'd7) begin n_fail++; $display("FAIL midclr_pre: got we=%b addr=%0d expected we=1 addr=7", we, wa); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (we !== 1'b0 || wa !== '0 || wd !== '0) begin n_fail++; $display("FAIL midclr_async: got we=%b addr=%0d data=%h expected all 0", we, wa, wd); end
        n_checks++; if (init_done !== 1'b0 || req_ready !== 2'b00) begin n_fail++; $display("FAIL midclr_status: got init_done=%b ready=%b expected 0/00", init_done, req_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 1; k <= SZ; k++) begin
            @(posedge clk); #1;
            n_checks++; if (we !== 1'b1 || wa !== AW'(k - 1)) begin n_fail++; $display("FAIL midclr_restart[%0d]: got we=%b addr=%0d expected we=1 addr=%0d", k, we, wa, k - 1); end
        end
        @(posedge clk); #1;
        n_checks++; if (init_done !== 1'b1 || we !== 1'b0) begin n_fail++; $display("FAIL midclr_done: got init_done=%b we=%b expected 1/0", init_done, we); end
        for (int i = 0; i < SZ; i++) exp_mem[i] = '0;
        ptr = 0;
    endtask

    task automatic test_no_clear();
        logic [DW-1:0] d;
        d = $urandom;
        reset = 1'b1;
        nc_req_valid = 2'b01; nc_req_addr[0] = 4'd9; nc_req_data[0] = d;
        @(posedge clk); #1;
        n_checks++; if (nc_init_done !== 1'b1 || nc_req_ready !== 2'b00) begin n_fail++; $display("FAIL nc_reset: got init_done=%b ready=%b expected 1/00", nc_init_done, nc_req_ready); end
        reset = 1'b0;
        #1;
        n_checks++; if (nc_req_ready !== 2'b01) begin n_fail++; $display("FAIL nc_first_grant: got %b expected 01", nc_req_ready); end
        @(posedge clk); #1;
        nc_req_valid = '0;
        n_checks++; if (nc_we !== 1'b1 || nc_wa !== 4'd9 || nc_wd !== d) begin n_fail++; $display("FAIL nc_write: got we=%b addr=%0d data=%h expected we=1 addr=9 data=%h", nc_we, nc_wa, nc_wd, d); end
        @(posedge clk); #1;
        n_checks++; if (nc_we !== 1'b0) begin n_fail++; $display("FAIL nc_idle_we: got %b expected 0", nc_we); end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        test_clear_sequence();
        test_readback("clear");
        test_single();
        test_back_to_back();
        test_random_traffic();
        test_readback("random");
        test_flush();
        test_readback("flush");
        test_reset_mid_clear();
        test_readback("midclr");
        test_no_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
